seg_scan_ctrl: RTL



---
 rtl/seg_scan_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scan controller with a double-buffered
// digit store: writes land in a shadow buffer, and a commit copies shadow to
// active at the end of a frame, or immediately when the display is off.
module seg_scan_ctrl #(
    parameter int DIGIT_TICKS = 50000,
    parameter int BLANK_TICKS = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       wr_dp,
    input  logic       wr_blank,
    input  logic       commit,
    output logic [7:0] seg,
    output logic [7:0] sel,
    output logic       frame_done
);

    typedef enum logic [1:0] {OFF, SHOW, BLANK} state_t;

    localparam logic [19:0] DLAST = 20'(DIGIT_TICKS - 1);
    localparam logic [19:0] BLAST = 20'(BLANK_TICKS - 1);
    // Buffer entry layout {blank, dp, value[3:0]}; reset value is a dark digit.
    localparam logic [5:0]  ENT_DARK = 6'b10_0000;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [19:0] cnt_q, cnt_d;
    logic        pending_q, pending_d;
    logic [5:0]  shadow_q [8];
    logic [5:0]  active_q [8];
    logic [7:0]  seg_q, seg_d;
    logic [7:0]  sel_q, sel_d;
    logic        copy;
    logic [5:0]  ent;
    logic [6:0]  code;

    // Active-low segment pattern g..a for a hex digit.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    // Frame end is the last BLANK cycle after digit 7; the copy happens at the
    // edge closing that cycle (or the first OFF cycle with a commit pending).
    // Writes are refused on the copy cycle so shadow is stable while copied.
    assign frame_done = ~rst & (state_q == BLANK) & (idx_q == 3'd7) & (cnt_q == BLAST);
    assign copy       = ~rst & pending_q & (frame_done | (state_q == OFF));
    assign wr_ready   = ~rst & ~copy;
    assign seg        = seg_q;
    assign sel        = sel_q;

    // Next-state: phase sequencing and pending-commit bookkeeping.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q + 20'd1;
        pending_d = (pending_q & ~copy) | commit;
        if (!enable) begin
            state_d = OFF;
            idx_d   = 3'd0;
            cnt_d   = 20'd0;
        end else begin
            case (state_q)
                OFF: begin
                    state_d = SHOW;
                    idx_d   = 3'd0;
                    cnt_d   = 20'd0;
                end
                SHOW: begin
                    if (cnt_q == DLAST) begin
                        state_d = BLANK;
                        cnt_d   = 20'd0;
                    end
                end
                BLANK: begin
                    if (cnt_q == BLAST) begin
                        state_d = SHOW;
                        idx_d   = idx_q + 3'd1;
                        cnt_d   = 20'd0;
                    end
                end
                default: begin
                    state_d = OFF;
                    idx_d   = 3'd0;
                    cnt_d   = 20'd0;
                end
            endcase
        end
    end

    // Output drive computed from the next state so seg and sel register on
    // the same edge as the phase change; on a copy edge use the incoming data.
    always_comb begin
        ent   = copy ? shadow_q[idx_d] : active_q[idx_d];
        code  = hex7(ent[3:0]);
        sel_d = 8'hFF;
        seg_d = 8'hFF;
        if (state_d == SHOW) begin
            sel_d = ~(8'd1 << idx_d);
            seg_d = ent[5] ? 8'hFF : {~ent[4], code};
        end
    end

    // State, outputs, and both digit buffers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= OFF;
            idx_q     <= 3'd0;
            cnt_q     <= 20'd0;
            pending_q <= 1'b0;
            seg_q     <= 8'hFF;
            sel_q     <= 8'hFF;
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= ENT_DARK;
                active_q[i] <= ENT_DARK;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            sel_q     <= sel_d;
            if (wr_valid && wr_ready)
                shadow_q[wr_addr] <= {wr_blank, wr_dp, wr_data};
            if (copy)
                active_q <= shadow_q;
        end
    end

endmodule
